// File: rtl/bomb_scheduler.sv
// Six-slot bomb fuse/blast scheduler with two-player placement arbitration and a detonation event stream.
// Optional macro BOMB_SCHED_DUP_CHECK_EN: nack any request whose tile matches a live (non-IDLE) slot.
module bomb_scheduler #(
  parameter int unsigned FUSE_FRAMES    = 180,
  parameter int unsigned BLAST_FRAMES   = 30,
  parameter int unsigned MAX_PER_PLAYER = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       game_reset,
  input  logic       frame_tick,
  input  logic       p1_req,
  input  logic       p2_req,
  input  logic [7:0] p1_tile,
  input  logic [7:0] p2_tile,
  output logic       p1_ack,
  output logic       p1_nack,
  output logic       p2_ack,
  output logic       p2_nack,
  input  logic [2:0] rd_id,
  output logic       rd_active,
  output logic       rd_exploding,
  output logic       rd_owner,
  output logic [7:0] rd_tile,
  output logic [2:0] p1_count,
  output logic [2:0] p2_count,
  output logic       exp_valid,
  output logic [7:0] exp_tile,
  input  logic       exp_ready
);
  localparam int unsigned NSLOT = 6;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_EXPLODING} slot_state_e;

  slot_state_e state_q [NSLOT];
  slot_state_e state_d [NSLOT];
  logic [7:0]  tile_q  [NSLOT];
  logic [7:0]  tile_d  [NSLOT];
  logic [7:0]  cnt_q   [NSLOT];
  logic [7:0]  cnt_d   [NSLOT];
  logic        owner_q [NSLOT];
  logic        owner_d [NSLOT];
  logic        pend_q  [NSLOT];
  logic        pend_d  [NSLOT];

  logic       p1_ack_q, p1_ack_d, p1_nack_q, p1_nack_d;
  logic       p2_ack_q, p2_ack_d, p2_nack_q, p2_nack_d;
  logic       prio_q, prio_d;
  logic       hold_q, hold_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] p1_count_q, p1_count_d, p2_count_q, p2_count_d;

  logic       p1_elig, p2_elig, eval_p1, eval_p2, req_valid;
  logic       req_full, req_dup, have_free, grant;
  logic [7:0] req_tile;
  logic       req_owner;
  logic [2:0] free_idx;

  logic       exp_any, exp_fire;
  logic [2:0] low_idx;
  logic [7:0] exp_tile_c;

  // Placement arbitration and evaluation
  always_comb begin
    p1_elig   = p1_req & ~p1_ack_q & ~p1_nack_q;
    p2_elig   = p2_req & ~p2_ack_q & ~p2_nack_q;
    eval_p1   = p1_elig & (~p2_elig | ~prio_q);
    eval_p2   = p2_elig & ~eval_p1;
    req_valid = eval_p1 | eval_p2;
    req_owner = eval_p2;
    req_tile  = eval_p2 ? p2_tile : p1_tile;
    req_full  = eval_p2 ? (p2_count_q >= 3'(MAX_PER_PLAYER))
                        : (p1_count_q >= 3'(MAX_PER_PLAYER));

    have_free = 1'b0;
    free_idx  = '0;
    for (int unsigned i = NSLOT; i > 0; i--) begin
      if (state_q[i-1] == ST_IDLE) begin
        have_free = 1'b1;
        free_idx  = 3'(i - 1);
      end
    end

    req_dup = 1'b0;
`ifdef BOMB_SCHED_DUP_CHECK_EN
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (state_q[i] != ST_IDLE && tile_q[i] == req_tile) req_dup = 1'b1;
    end
`endif

    grant     = req_valid & have_free & ~req_full & ~req_dup;
    p1_ack_d  = eval_p1 & grant;
    p1_nack_d = eval_p1 & ~grant;
    p2_ack_d  = eval_p2 & grant;
    p2_nack_d = eval_p2 & ~grant;
    prio_d    = (p1_elig & p2_elig) ? ~prio_q : prio_q;
  end

  // The presented slot is frozen while stalled so a newly pending lower slot cannot swap exp_tile.
  always_comb begin
    exp_any = 1'b0;
    low_idx = '0;
    for (int unsigned i = NSLOT; i > 0; i--) begin
      if (pend_q[i-1]) begin
        exp_any = 1'b1;
        low_idx = 3'(i - 1);
      end
    end
    sel_d      = hold_q ? sel_q : low_idx;
    exp_tile_c = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (exp_any && sel_d == 3'(i)) exp_tile_c = tile_q[i];
    end
    exp_fire = exp_any & exp_ready;
    hold_d   = exp_any & ~exp_ready;
  end

  assign exp_valid = exp_any;
  assign exp_tile  = exp_tile_c;

  // Slot next state: frame countdown, event consume, then allocation
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    pend_d  = pend_q;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (frame_tick) begin
        case (state_q[i])
          ST_ARMED: begin
            if (cnt_q[i] == 8'd1) begin
              state_d[i] = ST_EXPLODING;
              pend_d[i]  = 1'b1;
              cnt_d[i]   = 8'(BLAST_FRAMES);
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          ST_EXPLODING: begin
            if (cnt_q[i] == 8'd1) begin
              if (!pend_q[i]) begin
                state_d[i] = ST_IDLE;
                tile_d[i]  = '0;
                owner_d[i] = 1'b0;
                cnt_d[i]   = '0;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          default: ;
        endcase
      end
      if (exp_fire && sel_d == 3'(i)) pend_d[i] = 1'b0;
      if (grant && free_idx == 3'(i)) begin
        state_d[i] = ST_ARMED;
        tile_d[i]  = req_tile;
        owner_d[i] = req_owner;
        cnt_d[i]   = 8'(FUSE_FRAMES);
        pend_d[i]  = 1'b0;
      end
    end

    p1_count_d = '0;
    p2_count_d = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (state_d[i] != ST_IDLE) begin
        if (owner_d[i]) p2_count_d = p2_count_d + 3'd1;
        else            p1_count_d = p1_count_d + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset | game_reset) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        state_q[i] <= ST_IDLE;
        tile_q[i]  <= '0;
        cnt_q[i]   <= '0;
        owner_q[i] <= 1'b0;
        pend_q[i]  <= 1'b0;
      end
      p1_ack_q   <= 1'b0;
      p1_nack_q  <= 1'b0;
      p2_ack_q   <= 1'b0;
      p2_nack_q  <= 1'b0;
      prio_q     <= 1'b0;
      hold_q     <= 1'b0;
      sel_q      <= '0;
      p1_count_q <= '0;
      p2_count_q <= '0;
    end else begin
      state_q    <= state_d;
      tile_q     <= tile_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      pend_q     <= pend_d;
      p1_ack_q   <= p1_ack_d;
      p1_nack_q  <= p1_nack_d;
      p2_ack_q   <= p2_ack_d;
      p2_nack_q  <= p2_nack_d;
      prio_q     <= prio_d;
      hold_q     <= hold_d;
      sel_q      <= sel_d;
      p1_count_q <= p1_count_d;
      p2_count_q <= p2_count_d;
    end
  end

  assign p1_ack   = p1_ack_q;
  assign p1_nack  = p1_nack_q;
  assign p2_ack   = p2_ack_q;
  assign p2_nack  = p2_nack_q;
  assign p1_count = p1_count_q;
  assign p2_count = p2_count_q;

  always_comb begin
    rd_active    = 1'b0;
    rd_exploding = 1'b0;
    rd_owner     = 1'b0;
    rd_tile      = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (rd_id == 3'(i)) begin
        rd_active    = (state_q[i] != ST_IDLE);
        rd_exploding = (state_q[i] == ST_EXPLODING);
        rd_owner     = owner_q[i];
        rd_tile      = tile_q[i];
      end
    end
  end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed testbench for bomb_scheduler (FUSE=3, BLAST=2, MAX=3); expectation for duplicate tiles follows BOMB_SCHED_DUP_CHECK_EN.
module tb_bomb_scheduler;
  logic       clock = 1'b0;
  logic       reset, game_reset, frame_tick;
  logic       p1_req, p2_req;
  logic [7:0] p1_tile, p2_tile;
  logic       p1_ack, p1_nack, p2_ack, p2_nack;
  logic [2:0] rd_id;
  logic       rd_active, rd_exploding, rd_owner;
  logic [7:0] rd_tile;
  logic [2:0] p1_count, p2_count;
  logic       exp_valid;
  logic [7:0] exp_tile;
  logic       exp_ready;

  int n_checks = 0;
  int n_fail   = 0;

  bomb_scheduler #(.FUSE_FRAMES(3), .BLAST_FRAMES(2), .MAX_PER_PLAYER(3)) dut (
    .clock(clock), .reset(reset), .game_reset(game_reset), .frame_tick(frame_tick),
    .p1_req(p1_req), .p2_req(p2_req), .p1_tile(p1_tile), .p2_tile(p2_tile),
    .p1_ack(p1_ack), .p1_nack(p1_nack), .p2_ack(p2_ack), .p2_nack(p2_nack),
    .rd_id(rd_id), .rd_active(rd_active), .rd_exploding(rd_exploding),
    .rd_owner(rd_owner), .rd_tile(rd_tile), .p1_count(p1_count), .p2_count(p2_count),
    .exp_valid(exp_valid), .exp_tile(exp_tile), .exp_ready(exp_ready)
  );

  always #10 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic look(input logic [2:0] id);
    rd_id = id;
    #1;
  endtask

  task automatic clear_all();
    game_reset = 1'b1;
    step();
    game_reset = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic place1(input logic [7:0] t);
    p1_tile = t;
    p1_req  = 1'b1;
    step();
    p1_req  = 1'b0;
  endtask

  task automatic place2(input logic [7:0] t);
    p2_tile = t;
    p2_req  = 1'b1;
    step();
    p2_req  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; p1_tile = 8'h13; p1_req = 1'b1;
    step();
    step();
    n_checks++; if (p1_ack !== 1'b0) begin n_fail++; $display("FAIL rst_p1_ack: got %b want 0", p1_ack); end
    n_checks++; if ({p1_nack, p2_ack, p2_nack} !== 3'b000) begin n_fail++; $display("FAIL rst_acks: got %b want 000", {p1_nack, p2_ack, p2_nack}); end
    n_checks++; if ({exp_valid, exp_tile} !== 9'h000) begin n_fail++; $display("FAIL rst_exp: got %h want 000", {exp_valid, exp_tile}); end
    n_checks++; if ({p1_count, p2_count} !== 6'd0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d want 0/0", p1_count, p2_count); end
    for (int i = 0; i < 6; i++) begin
      look(3'(i));
      n_checks++; if ({rd_active, rd_exploding, rd_owner, rd_tile} !== 11'd0) begin n_fail++; $display("FAIL rst_slot%0d: got %h want 000", i, {rd_active, rd_exploding, rd_owner, rd_tile}); end
    end
    reset = 1'b0;
    step();
    p1_req = 1'b0;
    n_checks++; if (p1_ack !== 1'b1) begin n_fail++; $display("FAIL held_req_ack: got %b want 1", p1_ack); end
    n_checks++; if (p1_count !== 3'd1) begin n_fail++; $display("FAIL held_req_count: got %0d want 1", p1_count); end
  endtask

  task automatic test_first_place();
    clear_all();
    p1_tile = 8'h12; p1_req = 1'b1;
    step();
    n_checks++; if ({p1_ack, p1_nack} !== 2'b10) begin n_fail++; $display("FAIL first_ack: got %b want 10", {p1_ack, p1_nack}); end
    n_checks++; if (p1_count !== 3'd1) begin n_fail++; $display("FAIL first_count: got %0d want 1", p1_count); end
    look(3'd0);
    n_checks++; if ({rd_active, rd_exploding, rd_owner, rd_tile} !== {3'b100, 8'h12}) begin n_fail++; $display("FAIL first_slot0: got %h want %h", {rd_active, rd_exploding, rd_owner, rd_tile}, {3'b100, 8'h12}); end
    step();
    n_checks++; if ({p1_ack, p1_nack} !== 2'b00) begin n_fail++; $display("FAIL held_ignored: got %b want 00", {p1_ack, p1_nack}); end
    n_checks++; if (p1_count !== 3'd1) begin n_fail++; $display("FAIL held_ignored_count: got %0d want 1", p1_count); end
    p1_req = 1'b0;
  endtask

  task automatic test_contest();
    clear_all();
    p1_tile = 8'h21; p2_tile = 8'h22; p1_req = 1'b1; p2_req = 1'b1;
    step();
    p1_req = 1'b0;
    n_checks++; if ({p1_ack, p2_ack, p2_nack} !== 3'b100) begin n_fail++; $display("FAIL c1_first: got %b want 100", {p1_ack, p2_ack, p2_nack}); end
    look(3'd0);
    n_checks++; if ({rd_owner, rd_tile} !== {1'b0, 8'h21}) begin n_fail++; $display("FAIL c1_slot0: got %h want 021", {rd_owner, rd_tile}); end
    step();
    p2_req = 1'b0;
    n_checks++; if ({p1_ack, p2_ack} !== 2'b01) begin n_fail++; $display("FAIL c1_second: got %b want 01", {p1_ack, p2_ack}); end
    look(3'd1);
    n_checks++; if ({rd_owner, rd_tile} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL c1_slot1: got %h want 122", {rd_owner, rd_tile}); end
    step();
    p1_tile = 8'h31; p2_tile = 8'h32; p1_req = 1'b1; p2_req = 1'b1;
    step();
    p2_req = 1'b0;
    n_checks++; if ({p1_ack, p1_nack, p2_ack} !== 3'b001) begin n_fail++; $display("FAIL c2_first: got %b want 001", {p1_ack, p1_nack, p2_ack}); end
    look(3'd2);
    n_checks++; if ({rd_owner, rd_tile} !== {1'b1, 8'h32}) begin n_fail++; $display("FAIL c2_slot2: got %h want 132", {rd_owner, rd_tile}); end
    step();
    p1_req = 1'b0;
    n_checks++; if ({p1_ack, p2_ack} !== 2'b10) begin n_fail++; $display("FAIL c2_second: got %b want 10", {p1_ack, p2_ack}); end
    look(3'd3);
    n_checks++; if ({rd_owner, rd_tile} !== {1'b0, 8'h31}) begin n_fail++; $display("FAIL c2_slot3: got %h want 031", {rd_owner, rd_tile}); end
    n_checks++; if ({p1_count, p2_count} !== {3'd2, 3'd2}) begin n_fail++; $display("FAIL c2_counts: got %0d/%0d want 2/2", p1_count, p2_count); end
  endtask

  task automatic test_limits();
    clear_all();
    for (int i = 0; i < 3; i++) begin
      place1(8'h40 + 8'(i));
      n_checks++; if (p1_ack !== 1'b1) begin n_fail++; $display("FAIL lim_p1_ack%0d: got %b want 1", i, p1_ack); end
      step();
    end
    place1(8'h43);
    n_checks++; if ({p1_ack, p1_nack} !== 2'b01) begin n_fail++; $display("FAIL lim_p1_4th: got %b want 01", {p1_ack, p1_nack}); end
    n_checks++; if (p1_count !== 3'd3) begin n_fail++; $display("FAIL lim_p1_count: got %0d want 3", p1_count); end
    step();
    for (int i = 0; i < 3; i++) begin
      place2(8'h50 + 8'(i));
      n_checks++; if (p2_ack !== 1'b1) begin n_fail++; $display("FAIL lim_p2_ack%0d: got %b want 1", i, p2_ack); end
      step();
    end
    n_checks++; if (p2_count !== 3'd3) begin n_fail++; $display("FAIL lim_p2_count: got %0d want 3", p2_count); end
    place2(8'h61);
    n_checks++; if ({p2_ack, p2_nack} !== 2'b01) begin n_fail++; $display("FAIL lim_p2_7th: got %b want 01", {p2_ack, p2_nack}); end
    step();
    place1(8'h60);
    n_checks++; if ({p1_ack, p1_nack} !== 2'b01) begin n_fail++; $display("FAIL lim_p1_7th: got %b want 01", {p1_ack, p1_nack}); end
    look(3'd5);
    n_checks++; if ({rd_active, rd_owner, rd_tile} !== {2'b11, 8'h52}) begin n_fail++; $display("FAIL lim_slot5: got %h want 352", {rd_active, rd_owner, rd_tile}); end
    look(3'd6);
    n_checks++; if ({rd_active, rd_exploding, rd_owner, rd_tile} !== 11'd0) begin n_fail++; $display("FAIL rd_id6: got %h want 000", {rd_active, rd_exploding, rd_owner, rd_tile}); end
    look(3'd7);
    n_checks++; if ({rd_active, rd_exploding, rd_owner, rd_tile} !== 11'd0) begin n_fail++; $display("FAIL rd_id7: got %h want 000", {rd_active, rd_exploding, rd_owner, rd_tile}); end
  endtask

  task automatic test_detonate();
    clear_all();
    exp_ready = 1'b1;
    place1(8'h05);
    step();
    look(3'd0);
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_checks++; if ({exp_valid, rd_active, rd_exploding} !== 3'b010) begin n_fail++; $display("FAIL det_tick%0d: got %b want 010", i, {exp_valid, rd_active, rd_exploding}); end
    end
    tick();
    n_checks++; if ({exp_valid, exp_tile} !== {1'b1, 8'h05}) begin n_fail++; $display("FAIL det_event: got %h want 105", {exp_valid, exp_tile}); end
    n_checks++; if (rd_exploding !== 1'b1) begin n_fail++; $display("FAIL det_exploding: got %b want 1", rd_exploding); end
    step();
    n_checks++; if (exp_valid !== 1'b0) begin n_fail++; $display("FAIL det_consumed: got %b want 0", exp_valid); end
    tick();
    n_checks++; if ({rd_active, p1_count} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL det_tick4: got %b/%0d want 1/1", rd_active, p1_count); end
    tick();
    n_checks++; if ({rd_active, p1_count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL det_tick5: got %b/%0d want 0/0", rd_active, p1_count); end
  endtask

  task automatic test_back_to_back();
    clear_all();
    exp_ready = 1'b0;
    place1(8'h61);
    step();
    place2(8'h62);
    step();
    tick(); tick(); tick();
    n_checks++; if ({exp_valid, exp_tile} !== {1'b1, 8'h61}) begin n_fail++; $display("FAIL bp_first: got %h want 161", {exp_valid, exp_tile}); end
    for (int j = 0; j < 4; j++) begin
      frame_tick = (j < 3);
      step();
      frame_tick = 1'b0;
      n_checks++; if ({exp_valid, exp_tile} !== {1'b1, 8'h61}) begin n_fail++; $display("FAIL bp_stall%0d: got %h want 161", j, {exp_valid, exp_tile}); end
    end
    look(3'd0);
    n_checks++; if ({rd_active, rd_exploding} !== 2'b11) begin n_fail++; $display("FAIL bp_slot0_held: got %b want 11", {rd_active, rd_exploding}); end
    look(3'd1);
    n_checks++; if ({rd_active, rd_exploding} !== 2'b11) begin n_fail++; $display("FAIL bp_slot1_held: got %b want 11", {rd_active, rd_exploding}); end
    exp_ready = 1'b1;
    step();
    exp_ready = 1'b0;
    n_checks++; if ({exp_valid, exp_tile} !== {1'b1, 8'h62}) begin n_fail++; $display("FAIL bp_next: got %h want 162", {exp_valid, exp_tile}); end
    tick();
    look(3'd0);
    n_checks++; if ({rd_active, p1_count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL bp_slot0_freed: got %b/%0d want 0/0", rd_active, p1_count); end
    look(3'd1);
    n_checks++; if ({rd_active, p2_count, exp_tile} !== {1'b1, 3'd1, 8'h62}) begin n_fail++; $display("FAIL bp_slot1_wait: got %b/%0d/%h want 1/1/62", rd_active, p2_count, exp_tile); end
    place1(8'h63);
    look(3'd0);
    n_checks++; if ({p1_ack, rd_active, rd_tile} !== {2'b11, 8'h63}) begin n_fail++; $display("FAIL bp_realloc: got %h want 363", {p1_ack, rd_active, rd_tile}); end
    step();
    exp_ready = 1'b1;
    step();
    exp_ready = 1'b0;
    n_checks++; if (exp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", exp_valid); end
    tick();
    look(3'd1);
    n_checks++; if ({rd_active, p2_count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL bp_slot1_freed: got %b/%0d want 0/0", rd_active, p2_count); end
  endtask

  task automatic test_same_cycle();
    clear_all();
    exp_ready = 1'b1;
    p1_tile = 8'h70; p1_req = 1'b1; frame_tick = 1'b1;
    step();
    p1_req = 1'b0; frame_tick = 1'b0;
    n_checks++; if (p1_ack !== 1'b1) begin n_fail++; $display("FAIL sc_ack: got %b want 1", p1_ack); end
    step();
    tick(); tick();
    look(3'd0);
    n_checks++; if ({rd_active, rd_exploding} !== 2'b10) begin n_fail++; $display("FAIL sc_still_armed: got %b want 10", {rd_active, rd_exploding}); end
    tick();
    n_checks++; if ({rd_exploding, exp_valid, exp_tile} !== {2'b11, 8'h70}) begin n_fail++; $display("FAIL sc_explode: got %h want 370", {rd_exploding, exp_valid, exp_tile}); end
  endtask

  task automatic test_dup();
    logic exp_ack;
`ifdef BOMB_SCHED_DUP_CHECK_EN
    exp_ack = 1'b0;
`else
    exp_ack = 1'b1;
`endif
    clear_all();
    place1(8'h12);
    step();
    place2(8'h12);
    n_checks++; if ({p2_ack, p2_nack} !== {exp_ack, ~exp_ack}) begin n_fail++; $display("FAIL dup_tile: got %b want %b", {p2_ack, p2_nack}, {exp_ack, ~exp_ack}); end
  endtask

  initial begin
    reset = 1'b1; game_reset = 1'b0; frame_tick = 1'b0;
    p1_req = 1'b0; p2_req = 1'b0; p1_tile = '0; p2_tile = '0;
    rd_id = '0; exp_ready = 1'b0;
    test_reset();
    test_first_place();
    test_contest();
    test_limits();
    test_detonate();
    test_back_to_back();
    test_same_cycle();
    test_dup();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bomb_scheduler.md
BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

Interface
REQ-001 SHALL have parameter FUSE_FRAMES, default 180: frame ticks from placement to detonation, legal range 1..255.
REQ-002 SHALL have parameter BLAST_FRAMES, default 30: frame ticks a slot stays exploding, legal range 1..255.
REQ-003 SHALL have parameter MAX_PER_PLAYER, default 3: live bombs allowed per player, legal range 1..6.
REQ-004 SHALL have ports:
- clock  in  1  system clock; the block has one clock, and reset is synchronous and active-high
- reset  in  1  synchronous active-high reset
- game_reset  in  1  synchronous clear of all slots; same effect as reset
- frame_tick  in  1  one-cycle pulse per 60Hz frame
- p1_req, p2_req  in  1 each  placement request; held until acked or nacked
- p1_tile, p2_tile  in  8 each  tile index of the requested bomb
- p1_ack, p1_nack, p2_ack, p2_nack  out  1 each  one-cycle placement result
- rd_id  in  3  slot selector, values 0..5
- rd_active, rd_exploding, rd_owner  out  1 each  selected slot status; owner 0 = p1, 1 = p2
- rd_tile  out  8  selected slot tile
- p1_count, p2_count  out  3 each  live bombs per player
- exp_valid  out  1  detonation event valid
- exp_tile  out  8  tile of the detonation event
- exp_ready  in  1  event consumer ready

Function
REQ-005 SHALL hold 6 slots, each with state IDLE, ARMED or EXPLODING, plus an 8-bit tile, an owner bit, an 8-bit countdown and a pending flag.
REQ-006 SHALL evaluate at most one placement per cycle; on the cycle after a request is evaluated it SHALL pulse exactly one of that player's ack or nack.
REQ-007 SHALL ignore a player's request on the cycle its ack/nack is asserted, so a held request cannot be evaluated twice.
REQ-008 SHALL arbitrate simultaneous p1_req and p2_req round-robin. Priority starts at p1 after reset and toggles after every contested evaluation. The losing request stays pending and is evaluated the following cycle.
REQ-009 SHALL nack when no slot is IDLE or when the player's count equals MAX_PER_PLAYER. Otherwise it SHALL ack and allocate the lowest-index IDLE slot: state ARMED, tile latched, owner set, countdown = FUSE_FRAMES.
REQ-010 On frame_tick, each ARMED slot SHALL decrement its countdown. A slot with countdown 1 SHALL instead go to EXPLODING, set pending, and load countdown = BLAST_FRAMES.
REQ-011 On frame_tick, each EXPLODING slot SHALL decrement its countdown. At countdown 1 it SHALL go to IDLE, but only if pending is clear; otherwise it SHALL hold at 1 until pending clears.
REQ-012 SHALL drive exp_valid high while any slot has pending set, with exp_tile taken from the lowest-index pending slot. exp_tile SHALL stay stable while exp_valid is high and exp_ready is low.
REQ-013 SHALL clear the presented slot's pending flag on a cycle where exp_valid and exp_ready are both high; the next pending slot SHALL be presented on the following cycle.
REQ-014 SHALL NOT allocate a slot that frees on the same cycle; the freed slot becomes available the next cycle.
REQ-015 A placement and a frame_tick on the same cycle SHALL both take effect. The new slot does not decrement on its allocation cycle.
REQ-016 p1_count and p2_count SHALL equal the number of non-IDLE slots per owner, registered, and updated the cycle after any allocation or free.
REQ-017 The rd_* outputs SHALL be combinational from the slot registers. For rd_id values 6 and 7, every rd_* output SHALL be 0.

Reset
REQ-018 On reset or game_reset, all slots SHALL go IDLE with pending clear, tile 0, owner 0 and countdown 0.
REQ-019 On reset or game_reset, all ack/nack outputs, exp_valid, exp_tile and the counts SHALL be 0, and round-robin priority SHALL return to p1.
REQ-020 A request held across reset SHALL be evaluated normally on the first cycle after reset deasserts.

Configuration
REQ-021 SHALL support macro BOMB_SCHED_DUP_CHECK_EN.
- Defined: a request whose tile equals the tile of any non-IDLE slot SHALL be nacked.
- Undefined: no tile comparison is made, and duplicate tiles are accepted.

Verification
REQ-022 After reset, p1_req with tile 0x12 -> p1_ack one cycle later, slot 0 ARMED with tile 0x12, p1_count = 1.
REQ-023 p1_req and p2_req in the same cycle, both held -> cycle+1 p1_ack and slot 0 to p1; cycle+2 p2_ack and slot 1 to p2. Repeat the contest -> p2 wins first.
REQ-024 FUSE_FRAMES = 3, BLAST_FRAMES = 2, one bomb on tile 0x05, exp_ready = 1 -> exp_valid with tile 0x05 after the 3rd tick; slot goes IDLE after the 5th tick.
REQ-025 p1 places 3 bombs, then a 4th request -> p1_nack, p1_count stays 3; p2 places 3 -> all acked; 7th request from either player -> nack.
REQ-026 Two bombs detonate on the same tick with exp_ready = 0 for 4 cycles -> exp_tile stays at slot 0's tile; after ready, slot 1 is presented next; slots are freed only after their events are consumed.
REQ-027 With BOMB_SCHED_DUP_CHECK_EN defined, p2 requests tile 0x12 while p1's bomb is live on 0x12 -> p2_nack; with the macro undefined -> p2_ack.
